key_loader: RTL and testbench
=============================

Name: key_loader

Overview:
- Delivers the 32-bit unlock key to an RLL-locked netlist; drives its keyIn_0_* bus.
- Requests the key serially from the secure NVM shadow interface and verifies an 8-bit XOR checksum.
- Presents the key only after verification. Until then, and after zeroize, the key bus is all zeros, so the locked core stays corrupted.

Parameters:
KEY_WIDTH, 32, key bits; must be a multiple of 8
CHK_WIDTH, 8, checksum bits; fixed at 8
TIMEOUT, 16, maximum idle cycles between nvm_valid beats before the attempt is aborted
MAX_RETRY, 2, failed attempts allowed before permanent FAIL

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous reset, active low
start  input  1  one-cycle pulse; begins a load; ignored unless state is IDLE
zeroize  input  1  synchronous clear of key and status; highest priority after reset
nvm_req  output  1  high while a serial transfer is requested
nvm_valid  input  1  nvm_data is valid this cycle
nvm_data  input  1  serial data bit, LSB first
key_out  output  KEY_WIDTH  key bus to the locked core; zero unless key_valid
key_valid  output  1  key_out holds a verified key
busy  output  1  state is LOAD, CHECK or GAP
err  output  1  one-cycle pulse for each failed attempt (checksum mismatch or timeout)
fail  output  1  sticky; retries exhausted
retry_cnt  output  2  failed attempts so far in the current load

Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: state=IDLE, all outputs 0, internal shift register 0, bit counter 0, timeout counter 0.
- States:
  - IDLE: start moves to LOAD and clears bit counter, timeout counter and retry_cnt.
  - LOAD: nvm_req=1. Each cycle with nvm_valid=1 shifts nvm_data in, LSB first, and increments the bit counter.
    - The first KEY_WIDTH beats form key bits 0..KEY_WIDTH-1.
    - The next CHK_WIDTH beats form checksum bits 0..7.
    - After beat KEY_WIDTH+CHK_WIDTH is accepted, go to CHECK. nvm_req drops in the CHECK cycle.
  - Timeout in LOAD: the counter counts cycles with nvm_valid=0 and resets on each accepted beat. When it reaches TIMEOUT, the attempt fails.
  - CHECK: one cycle. Compare the XOR of key bytes [7:0], [15:8], … with the received checksum.
    - Match: latch key_out and set key_valid=1 on the edge ending CHECK; go to DONE.
    - Key latency: last beat at edge N → key_valid visible at N+2.
  - Failed attempt (mismatch or timeout): pulse err for 1 cycle.
    - If retry_cnt < MAX_RETRY: increment retry_cnt, go to GAP.
    - Otherwise: set fail=1 and go to FAIL.
  - GAP: one cycle with nvm_req=0. Clear bit counter and timeout counter, then return to LOAD (restart from bit 0).
  - DONE: hold key_out and key_valid. start is ignored.
  - FAIL: key_out=0, key_valid=0, fail=1. Only zeroize or reset exits.
- zeroize (any state, synchronous):
  - Next cycle: key_out=0, key_valid=0, fail=0, err=0, retry_cnt=0, nvm_req=0, state=IDLE.
  - zeroize together with start: zeroize wins and start is dropped.
- key_out is never driven from the live shift register. It changes only in CHECK (to the verified key) or on clear (to 0).
- nvm_valid outside LOAD is ignored. A beat arriving in the same cycle the timeout threshold is reached counts as a beat, so no timeout.
- busy = (state in LOAD, CHECK, GAP).
- Asserting rst_n low mid-transfer returns everything to reset values immediately (asynchronous).

Test Plan:
- Good load: start, then 40 contiguous beats of key 0xA5C30F12 LSB-first followed by checksum 0x7B → key_valid=1 and key_out=0xA5C30F12 two cycles after the last beat; err never pulses; busy falls.
- Bad checksum: same key with checksum 0x7A → err pulses, retry_cnt=1, nvm_req low for exactly 1 cycle, then a correct resend → key_valid=1, retry_cnt stays 1.
- Timeout: stall nvm_valid for 16 cycles after beat 10 → err pulse, GAP, restart. Three consecutive failures → fail=1, key_out=0, retry_cnt=2.
- Sparse beats: nvm_valid asserted every 15th cycle for all 40 beats → no timeout; key verified.
- Zeroize: in DONE, assert zeroize together with start → next cycle key_out=0, key_valid=0, state IDLE, no nvm_req.
- Async reset: drop rst_n at beat 20 without a clock edge → all outputs 0 immediately; after release, start reloads cleanly.

Source files
------------

// File: rtl/key_loader_if.sv
// key_loader_if
//   Serial link between the key loader and the secure NVM shadow port.
//   nvm_req   : loader asks for a serial key+checksum stream
//   nvm_valid : nvm_data carries a bit this cycle
//   nvm_data  : serial bit, LSB first (key bits first, then checksum bits)
//   master modport: the loader side; slave modport: the NVM side.
interface key_loader_if;
  logic nvm_req;
  logic nvm_valid;
  logic nvm_data;

  modport master (output nvm_req, input nvm_valid, input nvm_data);
  modport slave  (input nvm_req, output nvm_valid, output nvm_data);
endinterface

// File: rtl/key_loader.sv
// key_loader
//   Fetches the unlock key for an RLL-locked core from the NVM shadow port,
//   verifies its byte-wise XOR checksum and only then presents it on key_out.
//   Until a verified key exists (and after zeroize) key_out stays all zeros,
//   so the locked core keeps producing corrupted results.
//
// Ports
//   clk, rst_n  : single clock, asynchronous active-low reset
//   start       : one-cycle pulse, begins a load when idle
//   zeroize     : synchronous clear of key and status, beats everything but reset
//   nvm         : key_loader_if.master (nvm_req out, nvm_valid/nvm_data in)
//   key_out     : key bus to the locked core, zero unless key_valid
//   key_valid   : key_out holds a verified key
//   busy        : a load attempt is in progress (LOAD, CHECK or GAP)
//   err         : one-cycle pulse per failed attempt (bad checksum or timeout)
//   fail        : sticky, retries exhausted
//   retry_cnt   : failed attempts in the current load
module key_loader #(
  parameter int KEY_WIDTH = 32,
  parameter int CHK_WIDTH = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 zeroize,
  key_loader_if.master         nvm,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err,
  output logic                 fail,
  output logic [1:0]           retry_cnt
);

  localparam int TOT_BITS = KEY_WIDTH + CHK_WIDTH;
  localparam int NBYTES   = KEY_WIDTH / 8;
  localparam int BCW      = $clog2(TOT_BITS + 1);
  localparam int TCW      = $clog2(TIMEOUT + 1);

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(TOT_BITS - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);
  localparam logic [1:0]     RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                state_q, state_d;
  logic [TOT_BITS-1:0]   sr_q, sr_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0]        to_cnt_q, to_cnt_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic                  key_valid_q, key_valid_d;
  logic                  err_q, err_d;
  logic                  fail_q, fail_d;
  logic [1:0]            retry_q, retry_d;

  logic [CHK_WIDTH-1:0]  chk_calc;
  logic [CHK_WIDTH-1:0]  chk_rx;
  logic                  chk_ok;
  logic                  attempt_fail;

  // Checksum over the shifted-in frame. Bits arrive LSB first and enter at
  // the top of the shift register, so after a full frame bit 0 of the key
  // sits at sr_q[0] and the checksum occupies the top CHK_WIDTH bits.
  always_comb begin
    chk_calc = '0;
    for (int b = 0; b < NBYTES; b++) begin
      chk_calc = chk_calc ^ sr_q[b*8 +: 8];
    end
    chk_rx = sr_q[TOT_BITS-1 -: CHK_WIDTH];
    chk_ok = (chk_calc == chk_rx);
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    err_d        = 1'b0;
    fail_d       = fail_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;

    if (zeroize) begin
      // Wipes the key material too, not just the visible outputs.
      state_d     = S_IDLE;
      sr_d        = '0;
      bit_cnt_d   = '0;
      to_cnt_d    = '0;
      key_d       = '0;
      key_valid_d = 1'b0;
      fail_d      = 1'b0;
      retry_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            sr_d      = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            retry_d   = '0;
          end
        end

        S_LOAD: begin
          // A beat wins over the timeout even on the threshold cycle.
          if (nvm.nvm_valid) begin
            sr_d      = {nvm.nvm_data, sr_q[TOT_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            to_cnt_d  = '0;
            if (bit_cnt_q == LAST_BEAT) state_d = S_CHECK;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) attempt_fail = 1'b1;
          end
        end

        S_CHECK: begin
          if (chk_ok) begin
            key_d       = sr_q[KEY_WIDTH-1:0];
            key_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            attempt_fail = 1'b1;
          end
        end

        S_GAP: begin
          // Single idle cycle with nvm_req low, then restart from bit 0.
          sr_d      = '0;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = S_LOAD;
        end

        S_DONE: ;

        S_FAIL: begin
          key_d       = '0;
          key_valid_d = 1'b0;
          fail_d      = 1'b1;
        end

        default: state_d = S_IDLE;
      endcase

      if (attempt_fail) begin
        err_d = 1'b1;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = S_GAP;
        end else begin
          fail_d      = 1'b1;
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = S_FAIL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
    end
  end

  // key_out comes only from the verified-key register, never the shifter.
  assign key_out     = key_q;
  assign key_valid   = key_valid_q;
  assign err         = err_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign nvm.nvm_req = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                       (state_q == S_GAP);

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader
//   Directed bench for key_loader. A frame-level model (bit queue, checksum
//   by byte XOR, attempt/retry bookkeeping) predicts every output each cycle;
//   literal checks pin the model at the interesting points.
module tb_key_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        zeroize = 1'b0;
  logic [31:0] key_out;
  logic        key_valid, busy, err, fail;
  logic [1:0]  retry_cnt;

  key_loader_if nvm ();

  key_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .zeroize(zeroize),
    .nvm(nvm), .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .err(err), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int err_seen = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chk_of(input logic [31:0] k);
    logic [7:0] x;
    x = 8'h00;
    for (int b = 0; b < 4; b++) x = x ^ k[b*8 +: 8];
    return x;
  endfunction

  // ---------------- frame-level model ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_GAP = 3, P_DONE = 4, P_FAIL = 5;
  int          m_ph = P_IDLE;
  bit          m_bits[$];
  int          m_idle = 0;
  int          m_retry = 0;
  logic [31:0] m_key = '0;
  bit          m_kv = 1'b0, m_fail = 1'b0, m_err = 1'b0;
  logic [39:0] m_w;

  task automatic m_attempt_failed();
    m_err = 1'b1;
    if (m_retry < 2) begin
      m_retry++;
      m_ph = P_GAP;
    end else begin
      m_fail = 1'b1;
      m_key  = '0;
      m_kv   = 1'b0;
      m_ph   = P_FAIL;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_bits.delete(); m_idle = 0; m_retry = 0;
      m_key = '0; m_kv = 1'b0; m_fail = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (zeroize) begin
        m_ph = P_IDLE; m_bits.delete(); m_idle = 0; m_retry = 0;
        m_key = '0; m_kv = 1'b0; m_fail = 1'b0;
      end else begin
        case (m_ph)
          P_IDLE: if (start) begin
            m_ph = P_LOAD; m_bits.delete(); m_idle = 0; m_retry = 0;
          end
          P_LOAD: begin
            if (nvm.nvm_valid) begin
              m_bits.push_back(nvm.nvm_data);
              m_idle = 0;
              if (m_bits.size() == 40) m_ph = P_CHECK;
            end else begin
              m_idle++;
              if (m_idle == 16) m_attempt_failed();
            end
          end
          P_CHECK: begin
            for (int i = 0; i < 40; i++) m_w[i] = m_bits[i];
            if (chk_of(m_w[31:0]) == m_w[39:32]) begin
              m_key = m_w[31:0]; m_kv = 1'b1; m_ph = P_DONE;
            end else begin
              m_attempt_failed();
            end
          end
          P_GAP: begin
            m_bits.delete(); m_idle = 0; m_ph = P_LOAD;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("key_out",   key_out,     m_key);
      check("key_valid", key_valid,   m_kv);
      check("nvm_req",   nvm.nvm_req, (m_ph == P_LOAD));
      check("busy",      busy,        (m_ph == P_LOAD) || (m_ph == P_CHECK) || (m_ph == P_GAP));
      check("err",       err,         m_err);
      check("fail",      fail,        m_fail);
      check("retry_cnt", retry_cnt,   m_retry[1:0]);
      if (err === 1'b1) err_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_zeroize();
    zeroize = 1'b1; step(); zeroize = 1'b0;
  endtask

  task automatic send_bits(input logic [39:0] w, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      nvm.nvm_valid = 1'b1;
      nvm.nvm_data  = w[i];
      step();
      nvm.nvm_valid = 1'b0;
      nvm.nvm_data  = 1'b0;
      if (i < n - 1) repeat (gap) step();
    end
  endtask

  localparam logic [31:0] KEY  = 32'hA5C30F12;
  localparam logic [39:0] GOOD = {8'h7B, 32'hA5C30F12};
  localparam logic [39:0] BAD  = {8'h7A, 32'hA5C30F12};

  initial begin
    int e0;
    nvm.nvm_valid = 1'b0;
    nvm.nvm_data  = 1'b0;

    // reset
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    check("rst_key_out", key_out, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_retry", retry_cnt, 2'd0);
    check("chk_model", chk_of(KEY), 8'h7B);

    // good load, key latency two cycles after the last beat
    e0 = err_seen;
    pulse_start();
    check("load_req", nvm.nvm_req, 1'b1);
    send_bits(GOOD, 40, 0);
    check("check_cycle_kv", key_valid, 1'b0);
    check("check_cycle_req", nvm.nvm_req, 1'b0);
    step();
    check("good_kv", key_valid, 1'b1);
    check("good_key", key_out, 32'hA5C30F12);
    check("good_busy", busy, 1'b0);
    check("good_no_err", err_seen - e0, 0);

    // zeroize together with start in DONE
    zeroize = 1'b1; start = 1'b1; step(); zeroize = 1'b0; start = 1'b0;
    check("zero_key", key_out, 32'h0);
    check("zero_kv", key_valid, 1'b0);
    check("zero_req", nvm.nvm_req, 1'b0);
    step();
    check("zero_start_dropped", busy, 1'b0);

    // bad checksum, one retry, then correct resend
    e0 = err_seen;
    pulse_start();
    send_bits(BAD, 40, 0);
    step();
    check("bad_err", err, 1'b1);
    check("bad_gap_req", nvm.nvm_req, 1'b0);
    check("bad_retry", retry_cnt, 2'd1);
    step();
    check("bad_reload_req", nvm.nvm_req, 1'b1);
    send_bits(GOOD, 40, 0);
    step();
    check("retry_kv", key_valid, 1'b1);
    check("retry_key", key_out, 32'hA5C30F12);
    check("retry_cnt_kept", retry_cnt, 2'd1);
    check("retry_err_pulses", err_seen - e0, 1);

    // three timeouts -> FAIL
    pulse_zeroize();
    e0 = err_seen;
    pulse_start();
    send_bits(GOOD, 10, 0);
    repeat (53) step();
    check("to_fail", fail, 1'b1);
    check("to_key", key_out, 32'h0);
    check("to_kv", key_valid, 1'b0);
    check("to_retry", retry_cnt, 2'd2);
    check("to_err_pulses", err_seen - e0, 3);
    pulse_start();
    step();
    check("fail_ignores_start", busy, 1'b0);
    check("fail_sticky", fail, 1'b1);

    // sparse beats, every 15th cycle
    pulse_zeroize();
    check("zero_clears_fail", fail, 1'b0);
    e0 = err_seen;
    pulse_start();
    send_bits(GOOD, 40, 14);
    step();
    check("sparse_kv", key_valid, 1'b1);
    check("sparse_key", key_out, 32'hA5C30F12);
    check("sparse_no_err", err_seen - e0, 0);

    // beat lands on the 16th cycle after the previous one: still a beat
    pulse_zeroize();
    e0 = err_seen;
    pulse_start();
    send_bits(GOOD, 40, 15);
    step();
    check("edge_kv", key_valid, 1'b1);
    check("edge_no_err", err_seen - e0, 0);

    // async reset mid-transfer
    pulse_zeroize();
    pulse_start();
    send_bits(GOOD, 20, 0);
    check("pre_rst_busy", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", nvm.nvm_req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_key", key_out, 32'h0);
    check("arst_kv", key_valid, 1'b0);
    check("arst_retry", retry_cnt, 2'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    pulse_start();
    send_bits(GOOD, 40, 0);
    step();
    check("post_rst_kv", key_valid, 1'b1);
    check("post_rst_key", key_out, 32'hA5C30F12);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
